// File: rtl/can_level_stuff.sv
`default_nettype none
// ============================================================================
//  Module      : can_level_stuff
//  Description : CAN bit-stuffing layer between bit timing and packet layer.
//                Inserts/removes stuff bits, flags stuff violations and
//                accumulates CRC-15 over destuffed bits inside the window.
//  Revision    : 1.0 - initial release
// ============================================================================
module can_level_stuff #(
   parameter int unsigned STUFF_LEN = 5,
   parameter logic [14:0] CRC_POLY  = 15'h4599
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bit_req,
   input  logic        bit_rx,
   output logic        bit_tx,
   input  logic        stuff_en,
   output logic        usr_req,
   output logic        usr_rbit,
   input  logic        usr_tbit,
   output logic        stuff_slot,
   output logic        stuff_err,
   output logic [14:0] crc
);

   localparam logic [2:0] c_STUFF_LEN = 3'(STUFF_LEN);

   logic [2:0]  run_cnt_q,    run_cnt_d;
   logic        run_bit_q,    run_bit_d;
   logic        stuff_pend_q, stuff_pend_d;
   logic [14:0] crc_q,        crc_d;
   logic        bit_tx_q,     bit_tx_d;
   logic        usr_req_q,    usr_req_d;
   logic        usr_rbit_q,   usr_rbit_d;
   logic        stuff_slot_q, stuff_slot_d;
   logic        stuff_err_q,  stuff_err_d;
   // Set in the cycle after a bit border whose slot did not schedule a stuff
   // bit; that cycle latches the packet layer's next transmit bit.
   logic        tx_load_q,    tx_load_d;

   logic [2:0]  w_cnt_inc;
   logic [2:0]  w_run_next;
   logic [14:0] w_crc_next;

   // Run length, CRC step and next-state decision for each bit border
   always_comb begin
      w_cnt_inc    = (run_cnt_q == 3'd7) ? 3'd7 : run_cnt_q + 3'd1;
      w_run_next   = ((bit_rx == run_bit_q) && (run_cnt_q != 3'd0)) ? w_cnt_inc : 3'd1;
      w_crc_next   = {crc_q[13:0], 1'b0} ^ ((bit_rx ^ crc_q[14]) ? CRC_POLY : 15'd0);

      run_cnt_d    = run_cnt_q;
      run_bit_d    = run_bit_q;
      stuff_pend_d = stuff_pend_q;
      crc_d        = crc_q;
      bit_tx_d     = bit_tx_q;
      usr_rbit_d   = usr_rbit_q;
      usr_req_d    = 1'b0;
      stuff_slot_d = 1'b0;
      stuff_err_d  = 1'b0;
      tx_load_d    = 1'b0;

      if (tx_load_q) begin
         bit_tx_d = usr_tbit;
      end

      if (bit_req) begin
         tx_load_d = 1'b1;
         if (stuff_pend_q) begin
            // Stuff slot: honoured regardless of stuff_en, never delivered
            stuff_slot_d = 1'b1;
            stuff_pend_d = 1'b0;
            if (bit_rx == run_bit_q) begin
               stuff_err_d = 1'b1;
               run_cnt_d   = 3'd0;
            end else begin
               run_bit_d = bit_rx;
               run_cnt_d = 3'd1;
            end
         end else if (stuff_en) begin
            usr_req_d  = 1'b1;
            usr_rbit_d = bit_rx;
            run_bit_d  = bit_rx;
            run_cnt_d  = w_run_next;
            crc_d      = w_crc_next;
            if (w_run_next == c_STUFF_LEN) begin
               // Next slot is a stuff bit: transmit the complement of the run
               stuff_pend_d = 1'b1;
               tx_load_d    = 1'b0;
               bit_tx_d     = ~bit_rx;
            end
         end else begin
            usr_req_d  = 1'b1;
            usr_rbit_d = bit_rx;
            run_bit_d  = bit_rx;
            run_cnt_d  = 3'd0;
            crc_d      = 15'd0;
         end
      end
   end

   // State and output registers; reset drives the bus recessive at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_cnt_q    <= 3'd0;
         run_bit_q    <= 1'b1;
         stuff_pend_q <= 1'b0;
         crc_q        <= 15'd0;
         bit_tx_q     <= 1'b1;
         usr_req_q    <= 1'b0;
         usr_rbit_q   <= 1'b1;
         stuff_slot_q <= 1'b0;
         stuff_err_q  <= 1'b0;
         tx_load_q    <= 1'b0;
      end else begin
         run_cnt_q    <= run_cnt_d;
         run_bit_q    <= run_bit_d;
         stuff_pend_q <= stuff_pend_d;
         crc_q        <= crc_d;
         bit_tx_q     <= bit_tx_d;
         usr_req_q    <= usr_req_d;
         usr_rbit_q   <= usr_rbit_d;
         stuff_slot_q <= stuff_slot_d;
         stuff_err_q  <= stuff_err_d;
         tx_load_q    <= tx_load_d;
      end
   end

   assign bit_tx     = bit_tx_q;
   assign usr_req    = usr_req_q;
   assign usr_rbit   = usr_rbit_q;
   assign stuff_slot = stuff_slot_q;
   assign stuff_err  = stuff_err_q;
   assign crc        = crc_q;

endmodule
`default_nettype wire
